src_control_fsm: RTL and testbench

Hardwired control sequencer for the Mini SRC datapath. It steps a fetch phase (T0–T2), then an opcode-specific execute phase (T3–T7), and drives every bus-select, register-enable, memory and ALU-control strobe the datapath consumes. It sits beside the datapath and takes IR and the CON flag back as inputs. Outputs are a Moore-style decode of the current step, the latched IR opcode and CON.

---
 rtl/src_ctrl_pkg.sv | 76 +++++++
 rtl/src_step_decoder.sv | 133 +++++++++++++
 rtl/src_control_fsm.sv | 113 +++++++++++
 tb/tb_src_control_fsm.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit.
// Holds the opcode map, the ALU add code used by the fetch and address steps,
// the control-step enumeration, the per-step strobe bundle and a helper that
// groups opcodes into execute classes sharing one step sequence.
package src_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BRX  = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } step_e;

  typedef enum logic [3:0] {
    CL_RALU, CL_IALU, CL_LDI, CL_LD, CL_ST, CL_MD, CL_NEGNOT, CL_BRX,
    CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
  } class_e;

  typedef struct packed {
    logic       pout, mdrout, zhiout, zloout, hiout, loout, cout, inportout;
    logic       pen, iren, maren, mdren, yen, zen, hien, loen, outporten, incpc;
    logic       read, write;
    logic       gra, grb, grc, rin, rout, baout, conin;
    logic [4:0] alu_control;
  } ctrl_t;

  function automatic class_e op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:            return CL_RALU;
      OP_ADDI, OP_ANDI, OP_ORI:                 return CL_IALU;
      OP_LDI:                                   return CL_LDI;
      OP_LD:                                    return CL_LD;
      OP_ST:                                    return CL_ST;
      OP_MUL, OP_DIV:                           return CL_MD;
      OP_NEG, OP_NOT:                           return CL_NEGNOT;
      OP_BRX:                                   return CL_BRX;
      OP_JR:                                    return CL_JR;
      OP_IN:                                    return CL_IN;
      OP_OUT:                                   return CL_OUT;
      OP_MFHI:                                  return CL_MFHI;
      OP_MFLO:                                  return CL_MFLO;
      OP_NOP:                                   return CL_NOP;
      OP_HALT:                                  return CL_HALT;
      default:                                  return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/src_step_decoder.sv
// Combinational step decoder: maps (step, opcode, con) to the strobe bundle.
// Ports:
//   step    - current control step
//   op      - opcode field of IR (only meaningful in T3..T7)
//   con     - branch condition, used only in brx T6
//   ctrl    - strobe bundle for this step
//   last    - this step is the final execute step of the instruction
//   halt_op - the instruction is halt (valid on its last step)
//   illegal - the opcode is undefined (valid on its last step, T3)
module src_step_decoder
  import src_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  step_e          step,
  input  logic [OPW-1:0] op,
  input  logic           con,
  output ctrl_t          ctrl,
  output logic           last,
  output logic           halt_op,
  output logic           illegal
);

  class_e cls;

  always_comb begin
    ctrl    = '0;
    last    = 1'b0;
    halt_op = 1'b0;
    illegal = 1'b0;
    cls     = op_class(op);
    case (step)
      T0: begin
        ctrl.pout = 1'b1; ctrl.maren = 1'b1; ctrl.incpc = 1'b1;
        ctrl.zen = 1'b1; ctrl.alu_control = ALU_ADD;
      end
      T1: begin
        ctrl.zloout = 1'b1; ctrl.pen = 1'b1; ctrl.read = 1'b1; ctrl.mdren = 1'b1;
      end
      T2: begin
        ctrl.mdrout = 1'b1; ctrl.iren = 1'b1;
      end
      HALT: ;
      default: begin
        // Steps past a class's final step are unreachable; flagging them as
        // last keeps the sequencer from wandering if that ever happens.
        case (cls)
          CL_RALU, CL_IALU: begin
            case (step)
              T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.yen = 1'b1; end
              T4: begin
                if (cls == CL_IALU) ctrl.cout = 1'b1;
                else begin ctrl.grc = 1'b1; ctrl.rout = 1'b1; end
                ctrl.zen = 1'b1; ctrl.alu_control = op;
              end
              T5: begin ctrl.zloout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; last = 1'b1; end
              default: last = 1'b1;
            endcase
          end
          CL_LDI, CL_LD, CL_ST: begin
            case (step)
              T3: begin ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.yen = 1'b1; end
              T4: begin ctrl.cout = 1'b1; ctrl.zen = 1'b1; ctrl.alu_control = ALU_ADD; end
              T5: begin
                ctrl.zloout = 1'b1;
                if (cls == CL_LDI) begin ctrl.gra = 1'b1; ctrl.rin = 1'b1; last = 1'b1; end
                else ctrl.maren = 1'b1;
              end
              T6: begin
                ctrl.mdren = 1'b1;
                if (cls == CL_LD) ctrl.read = 1'b1;
                else begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; end
              end
              T7: begin
                if (cls == CL_LD) begin ctrl.mdrout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                else ctrl.write = 1'b1;
                last = 1'b1;
              end
              default: last = 1'b1;
            endcase
          end
          CL_MD: begin
            case (step)
              T3: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.yen = 1'b1; end
              T4: begin
                ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zen = 1'b1; ctrl.alu_control = op;
              end
              T5: begin ctrl.zloout = 1'b1; ctrl.loen = 1'b1; end
              T6: begin ctrl.zhiout = 1'b1; ctrl.hien = 1'b1; last = 1'b1; end
              default: last = 1'b1;
            endcase
          end
          CL_NEGNOT: begin
            case (step)
              T3: begin
                ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zen = 1'b1; ctrl.alu_control = op;
              end
              T4: begin ctrl.zloout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; last = 1'b1; end
              default: last = 1'b1;
            endcase
          end
          CL_BRX: begin
            case (step)
              T3: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.conin = 1'b1; end
              T4: begin ctrl.pout = 1'b1; ctrl.yen = 1'b1; end
              T5: begin ctrl.cout = 1'b1; ctrl.zen = 1'b1; ctrl.alu_control = ALU_ADD; end
              // Branch target is always computed; con only gates the PC load.
              T6: begin ctrl.zloout = 1'b1; ctrl.pen = con; last = 1'b1; end
              default: last = 1'b1;
            endcase
          end
          default: begin
            // Single-step classes finish in T3.
            last = 1'b1;
            if (step == T3) begin
              case (cls)
                CL_JR:   begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pen = 1'b1; end
                CL_IN:   begin ctrl.inportout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                CL_OUT:  begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outporten = 1'b1; end
                CL_MFHI: begin ctrl.hiout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                CL_MFLO: begin ctrl.loout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                CL_HALT: halt_op = 1'b1;
                CL_ILL:  illegal = 1'b1;
                default: ;
              endcase
            end
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/src_control_fsm.sv
// Mini SRC hardwired control sequencer.
// Steps T0..T2 (fetch) then T3..T7 (opcode-specific execute), or parks in HALT.
// Ports:
//   clk, clr          - clock (rising edge), asynchronous active-low reset
//   ir, con, stop     - instruction word, branch condition, halt request
//   Pout..InPortout   - bus source selects
//   Pen..IncPC        - register enables
//   Read, Write       - RAM strobes
//   Gra..ConIn        - register select encoder and CON controls
//   alu_control       - ALU operation code
//   run               - high while executing
//   illegal_op        - one-cycle pulse in T3 of an undefined opcode
module src_control_fsm
  import src_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0,
  parameter int OPW             = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        Pout, MDRout, ZHIout, ZLOout, HIout, LOout, Cout, InPortout,
  output logic        Pen, IRen, MARen, MDRen, Yen, Zen, HIen, LOen, OutPorten, IncPC,
  output logic        Read, Write,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, ConIn,
  output logic [4:0]  alu_control,
  output logic        run,
  output logic        illegal_op
);

  step_e          step_q, step_d;
  logic           started_q;
  logic           stop_pend_q;
  logic [OPW-1:0] op;
  logic           unused_ir;
  ctrl_t          dec_ctrl, ctrl_g;
  logic           dec_last, dec_halt, dec_ill, end_halt;

  assign op        = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];

  src_step_decoder #(.OPW(OPW)) u_dec (
    .step    (step_q),
    .op      (op),
    .con     (con),
    .ctrl    (dec_ctrl),
    .last    (dec_last),
    .halt_op (dec_halt),
    .illegal (dec_ill)
  );

  // started_q holds the machine idle in T0 for the first edge after clr
  // rises, so strobes stay low until run is asserted.
  assign run = started_q && (step_q != HALT);

  always_comb begin
    end_halt = dec_halt || (HALT_ON_ILLEGAL && dec_ill) || stop || stop_pend_q;
    step_d   = step_q;
    if (!started_q)            step_d = T0;
    else if (step_q == HALT)   step_d = HALT;
    else if (dec_last)         step_d = end_halt ? HALT : T0;
    else                       step_d = step_e'(step_q + 4'd1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      step_q      <= T0;
      started_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      step_q    <= step_d;
      started_q <= 1'b1;
      // A stop seen anywhere in an instruction is remembered until the next fetch.
      if (step_d == T0)  stop_pend_q <= 1'b0;
      else if (stop)     stop_pend_q <= 1'b1;
    end
  end

  assign ctrl_g     = run ? dec_ctrl : '0;
  assign illegal_op = run & dec_ill;

  assign Pout        = ctrl_g.pout;
  assign MDRout      = ctrl_g.mdrout;
  assign ZHIout      = ctrl_g.zhiout;
  assign ZLOout      = ctrl_g.zloout;
  assign HIout       = ctrl_g.hiout;
  assign LOout       = ctrl_g.loout;
  assign Cout        = ctrl_g.cout;
  assign InPortout   = ctrl_g.inportout;
  assign Pen         = ctrl_g.pen;
  assign IRen        = ctrl_g.iren;
  assign MARen       = ctrl_g.maren;
  assign MDRen       = ctrl_g.mdren;
  assign Yen         = ctrl_g.yen;
  assign Zen         = ctrl_g.zen;
  assign HIen        = ctrl_g.hien;
  assign LOen        = ctrl_g.loen;
  assign OutPorten   = ctrl_g.outporten;
  assign IncPC       = ctrl_g.incpc;
  assign Read        = ctrl_g.read;
  assign Write       = ctrl_g.write;
  assign Gra         = ctrl_g.gra;
  assign Grb         = ctrl_g.grb;
  assign Grc         = ctrl_g.grc;
  assign Rin         = ctrl_g.rin;
  assign Rout        = ctrl_g.rout;
  assign BAout       = ctrl_g.baout;
  assign ConIn       = ctrl_g.conin;
  assign alu_control = ctrl_g.alu_control;

endmodule

// File: tb/tb_src_control_fsm.sv
// Directed bench for src_control_fsm: expected per-cycle output vectors come
// from an independent instruction-timing model and are queued, then compared
// against the DUT one cycle at a time.
module tb_src_control_fsm;

  logic        clk = 1'b0;
  logic        clr, con, stop;
  logic [31:0] ir;
  logic Pout, MDRout, ZHIout, ZLOout, HIout, LOout, Cout, InPortout;
  logic Pen, IRen, MARen, MDRen, Yen, Zen, HIen, LOen, OutPorten, IncPC;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, ConIn;
  logic [4:0] alu_control;
  logic run, illegal_op;

  always #5 clk = ~clk;

  src_control_fsm #(.HALT_ON_ILLEGAL(1'b0), .OPW(5)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con(con), .stop(stop),
    .Pout(Pout), .MDRout(MDRout), .ZHIout(ZHIout), .ZLOout(ZLOout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
    .Pen(Pen), .IRen(IRen), .MARen(MARen), .MDRen(MDRen), .Yen(Yen), .Zen(Zen),
    .HIen(HIen), .LOen(LOen), .OutPorten(OutPorten), .IncPC(IncPC),
    .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .ConIn(ConIn),
    .alu_control(alu_control), .run(run), .illegal_op(illegal_op)
  );

  localparam int POUT = 0, MDROUT = 1, ZHIOUT = 2, ZLOOUT = 3, HIOUT = 4, LOOUT = 5;
  localparam int COUT = 6, INPORTOUT = 7, PEN = 8, IREN = 9, MAREN = 10, MDREN = 11;
  localparam int YEN = 12, ZEN = 13, HIEN = 14, LOEN = 15, OUTPORTEN = 16, INCPC = 17;
  localparam int READ = 18, WRITE = 19, GRA = 20, GRB = 21, GRC = 22, RIN = 23;
  localparam int ROUT = 24, BAOUT = 25, CONIN = 26, ILL = 32, RUN = 33;

  logic [33:0] obs;
  assign obs = {run, illegal_op, alu_control, ConIn, BAout, Rout, Rin, Grc, Grb, Gra,
                Write, Read, IncPC, OutPorten, LOen, HIen, Zen, Yen, MDRen, MARen,
                IRen, Pen, InPortout, Cout, LOout, HIout, ZLOout, ZHIout, MDRout, Pout};

  int          vectors = 0;
  int          miscompares = 0;
  logic [33:0] exp_q[$];
  string       tag_q[$];
  logic [4:0]  misc_ops [0:14];

  function automatic logic [33:0] b(input int i);
    return 34'd1 << i;
  endfunction

  function automatic logic [33:0] alu(input logic [4:0] a);
    return {2'b00, a, 27'd0};
  endfunction

  function automatic int ilen(input logic [4:0] op);
    if ((op >= 5'd3 && op <= 5'd14) || op == 5'd1) return 6;
    if (op == 5'd0 || op == 5'd2)                   return 8;
    if (op == 5'd15 || op == 5'd16 || op == 5'd19)  return 7;
    if (op == 5'd17 || op == 5'd18)                 return 5;
    return 4;
  endfunction

  function automatic logic [33:0] model(input logic [4:0] op, input int k, input logic c);
    logic [33:0] v;
    v = b(RUN);
    if (k == 0)      v |= b(POUT) | b(MAREN) | b(INCPC) | b(ZEN) | alu(5'b00011);
    else if (k == 1) v |= b(ZLOOUT) | b(PEN) | b(READ) | b(MDREN);
    else if (k == 2) v |= b(MDROUT) | b(IREN);
    else if (op >= 5'd3 && op <= 5'd14) begin
      if (k == 3)      v |= b(GRB) | b(ROUT) | b(YEN);
      else if (k == 4) v |= ((op >= 5'd12) ? b(COUT) : (b(GRC) | b(ROUT))) | b(ZEN) | alu(op);
      else             v |= b(ZLOOUT) | b(GRA) | b(RIN);
    end else if (op <= 5'd2) begin
      if (k == 3)      v |= b(GRB) | b(BAOUT) | b(YEN);
      else if (k == 4) v |= b(COUT) | b(ZEN) | alu(5'b00011);
      else if (k == 5) v |= b(ZLOOUT) | ((op == 5'd1) ? (b(GRA) | b(RIN)) : b(MAREN));
      else if (k == 6) v |= (op == 5'd0) ? (b(READ) | b(MDREN)) : (b(GRA) | b(ROUT) | b(MDREN));
      else             v |= (op == 5'd0) ? (b(MDROUT) | b(GRA) | b(RIN)) : b(WRITE);
    end else if (op == 5'd15 || op == 5'd16) begin
      if (k == 3)      v |= b(GRA) | b(ROUT) | b(YEN);
      else if (k == 4) v |= b(GRB) | b(ROUT) | b(ZEN) | alu(op);
      else if (k == 5) v |= b(ZLOOUT) | b(LOEN);
      else             v |= b(ZHIOUT) | b(HIEN);
    end else if (op == 5'd17 || op == 5'd18) begin
      if (k == 3) v |= b(GRB) | b(ROUT) | b(ZEN) | alu(op);
      else        v |= b(ZLOOUT) | b(GRA) | b(RIN);
    end else if (op == 5'd19) begin
      if (k == 3)      v |= b(GRA) | b(ROUT) | b(CONIN);
      else if (k == 4) v |= b(POUT) | b(YEN);
      else if (k == 5) v |= b(COUT) | b(ZEN) | alu(5'b00011);
      else             v |= b(ZLOOUT) | (c ? b(PEN) : 34'd0);
    end else begin
      case (op)
        5'd20:        v |= b(GRA) | b(ROUT) | b(PEN);
        5'd22:        v |= b(INPORTOUT) | b(GRA) | b(RIN);
        5'd23:        v |= b(GRA) | b(ROUT) | b(OUTPORTEN);
        5'd24:        v |= b(HIOUT) | b(GRA) | b(RIN);
        5'd25:        v |= b(LOOUT) | b(GRA) | b(RIN);
        5'd26, 5'd27: ;
        default:      v |= b(ILL);
      endcase
    end
    return v;
  endfunction

  task automatic push(input logic [33:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check();
    logic [33:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic do_instr(input logic [31:0] w, input logic c, input int stop_at,
                          input int clr_at, input string nm);
    for (int k = 0; k < ilen(w[31:27]); k++) begin
      @(negedge clk);
      ir   = w;
      con  = c;
      stop = (k == stop_at);
      push(model(w[31:27], k, c), $sformatf("%s.T%0d", nm, k));
      #1 check();
      if (k == clr_at) begin
        clr = 1'b0;
        #1;
        push(34'd0, {nm, ".clr_async"});
        check();
        return;
      end
    end
  endtask

  task automatic do_halt(input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ir   = $urandom;
      con  = 1'($urandom);
      stop = 1'($urandom);
      push(34'd0, $sformatf("%s.%0d", nm, k));
      #1 check();
    end
    stop = 1'b0;
  endtask

  initial begin
    misc_ops = '{5'd1, 5'd4, 5'd6, 5'd9, 5'd12, 5'd14, 5'd16, 5'd17,
                 5'd18, 5'd20, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};
    clr  = 1'b0;
    ir   = 32'd0;
    con  = 1'b0;
    stop = 1'b0;
    #3;
    push(34'd0, "reset");
    check();
    @(negedge clk);
    clr = 1'b1;

    do_instr(32'h19890000, 1'b0, -1, -1, "add");
    do_instr({5'b00000, 27'($urandom)}, 1'b0, -1, -1, "ld");
    do_instr({5'b00010, 27'($urandom)}, 1'b0, -1, -1, "st");
    do_instr({5'b10011, 27'($urandom)}, 1'b0, -1, -1, "brx_c0");
    do_instr({5'b10011, 27'($urandom)}, 1'b1, -1, -1, "brx_c1");
    for (int i = 0; i < 15; i++)
      do_instr({misc_ops[i], 27'($urandom)}, 1'b0, -1, -1, $sformatf("op%0d", misc_ops[i]));
    do_instr({5'b11111, 27'($urandom)}, 1'b0, -1, -1, "ill31");
    do_instr({5'b10101, 27'($urandom)}, 1'b0, -1, -1, "ill21");
    do_instr(32'h19890000, 1'b0, -1, -1, "add_after_ill");

    // Reset pulled in T4 of ld; outputs must clear at once and stay clear.
    do_instr({5'b00000, 27'($urandom)}, 1'b0, -1, 4, "ld_clr");
    @(negedge clk);
    push(34'd0, "clr_hold");
    #1 check();
    clr = 1'b1;
    do_instr({5'b00011, 27'($urandom)}, 1'b0, -1, -1, "add_after_clr");

    // Stop pulsed during T1 of mul: mul completes, then HALT.
    do_instr({5'b01111, 27'($urandom)}, 1'b0, 1, -1, "mul_stop");
    do_halt(5, "halt_stop");

    @(negedge clk);
    clr = 1'b0;
    #1;
    push(34'd0, "clr_from_halt");
    check();
    @(negedge clk);
    clr = 1'b1;
    do_instr({5'b11011, 27'($urandom)}, 1'b0, -1, -1, "halt_op");
    do_halt(3, "halt_after_op");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
